// File: rtl/wash_panel_seq.sv
// Operator-panel sequencer for the washing machine controller: debounces buttons,
// drives request levels, owns door lock, buzzer, LEDs and the run timeout.
module wash_panel_seq #(
   parameter int unsigned DEB_CYCLES     = 4,
   parameter int unsigned REQ_HOLD       = 3,
   parameter int unsigned TIMEOUT_CYCLES = 200,
   parameter int unsigned BUZZ_CYCLES    = 8
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_btn_load,
   input  logic       i_btn_det,
   input  logic       i_btn_start,
   input  logic       i_btn_cancel,
   input  logic       i_water_ok,
   input  logic       i_finish,
   input  logic       i_error,
   output logic       o_clothes,
   output logic       o_det_liquid,
   output logic       o_water_tap,
   output logic       o_door_lock,
   output logic       o_busy,
   output logic       o_buzzer,
   output logic       o_done_led,
   output logic       o_err_led,
   output logic [1:0] o_fault_code
);

   localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);
   localparam int unsigned CNT_W = 16;
   localparam int unsigned NBTN  = 4;
   localparam int unsigned B_LOAD   = 0;
   localparam int unsigned B_DET    = 1;
   localparam int unsigned B_START  = 2;
   localparam int unsigned B_CANCEL = 3;

   localparam logic [1:0] CODE_NONE    = 2'b00;
   localparam logic [1:0] CODE_NOWATER = 2'b01;
   localparam logic [1:0] CODE_TIMEOUT = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARMED,
      S_REQUEST,
      S_RUN,
      S_DONE,
      S_FAULT
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [DEB_W-1:0]   r_deb [NBTN];
   logic [NBTN-1:0]    w_raw;
   logic [NBTN-1:0]    w_press;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic               r_load_l;
   logic               r_det_l;
   logic               w_load_nxt;
   logic               w_det_nxt;
   logic [1:0]         w_code_nxt;

   assign w_raw = {i_btn_cancel, i_btn_start, i_btn_det, i_btn_load};

   // Saturating debounce counters; a press fires once, on the cycle the count reaches DEB_CYCLES.
   always_ff @(posedge i_clk) begin
      for (int i = 0; i < int'(NBTN); i++) begin
         if (i_rst || !w_raw[i]) begin
            r_deb[i] <= '0;
         end else if (r_deb[i] != DEB_W'(DEB_CYCLES)) begin
            r_deb[i] <= r_deb[i] + DEB_W'(1);
         end
      end
   end

   always_comb begin
      for (int i = 0; i < int'(NBTN); i++) begin
         w_press[i] = w_raw[i] && (r_deb[i] == DEB_W'(DEB_CYCLES - 1));
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_load_l <= 1'b0;
         r_det_l  <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_load_l <= w_load_nxt;
         r_det_l  <= w_det_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_code_nxt  = o_fault_code;
      w_load_nxt  = r_load_l;
      w_det_nxt   = r_det_l;
      w_cnt_nxt   = r_cnt;

      case (r_state)
         S_IDLE: begin
            w_load_nxt = r_load_l | w_press[B_LOAD];
            w_det_nxt  = r_det_l  | w_press[B_DET];
            if (w_load_nxt && w_det_nxt) begin
               w_state_nxt = S_ARMED;
            end
         end
         S_ARMED: begin
            if (w_press[B_CANCEL]) begin
               w_state_nxt = S_IDLE;
            end else if (w_press[B_START]) begin
               if (i_water_ok) begin
                  w_state_nxt = S_REQUEST;
               end else begin
                  w_state_nxt = S_FAULT;
                  w_code_nxt  = CODE_NOWATER;
               end
            end
         end
         S_REQUEST: begin
            if (i_error) begin
               w_state_nxt = S_FAULT;
               w_code_nxt  = CODE_NOWATER;
            end else if (w_press[B_CANCEL]) begin
               w_state_nxt = S_IDLE;
            end else if (r_cnt == CNT_W'(REQ_HOLD - 1)) begin
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            // finish beats the timeout when both land on the same cycle
            if (i_finish) begin
               w_state_nxt = S_DONE;
            end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               w_state_nxt = S_FAULT;
               w_code_nxt  = CODE_TIMEOUT;
            end
         end
         S_DONE: begin
            if (r_cnt == CNT_W'(BUZZ_CYCLES - 1)) begin
               w_state_nxt = S_IDLE;
            end
         end
         S_FAULT: begin
            if (w_press[B_CANCEL]) begin
               w_state_nxt = S_IDLE;
               w_code_nxt  = CODE_NONE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_code_nxt  = CODE_NONE;
         end
      endcase

      if (w_state_nxt == S_IDLE && r_state != S_IDLE) begin
         w_load_nxt = 1'b0;
         w_det_nxt  = 1'b0;
      end

      // One shared counter serves as hold, run timer and buzzer count; it restarts on every state change.
      if (w_state_nxt != r_state) begin
         w_cnt_nxt = '0;
      end else if (r_state == S_REQUEST || r_state == S_RUN || r_state == S_DONE) begin
         w_cnt_nxt = r_cnt + CNT_W'(1);
      end
   end

   // Outputs are registered decodes of the next state.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_clothes    <= 1'b0;
         o_det_liquid <= 1'b0;
         o_water_tap  <= 1'b0;
         o_door_lock  <= 1'b0;
         o_busy       <= 1'b0;
         o_buzzer     <= 1'b0;
         o_done_led   <= 1'b0;
         o_err_led    <= 1'b0;
         o_fault_code <= CODE_NONE;
      end else begin
         o_clothes    <= (w_state_nxt == S_REQUEST);
         o_det_liquid <= (w_state_nxt == S_REQUEST);
         o_water_tap  <= (w_state_nxt == S_REQUEST);
         o_door_lock  <= (w_state_nxt == S_REQUEST) || (w_state_nxt == S_RUN);
         o_busy       <= (w_state_nxt == S_REQUEST) || (w_state_nxt == S_RUN);
         o_buzzer     <= (w_state_nxt == S_DONE);
         o_done_led   <= (w_state_nxt == S_DONE);
         o_err_led    <= (w_state_nxt == S_FAULT);
         o_fault_code <= w_code_nxt;
      end
   end

endmodule

// File: tb/tb_wash_panel_seq.sv
// Directed bench for wash_panel_seq: a vector table for the main flows plus
// hand-written run/timeout/reset sequences.
module tb_wash_panel_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_load, btn_det, btn_start, btn_cancel, water_ok, finish, error;
   logic       clothes, det_liquid, water_tap, door_lock, busy, buzzer, done_led, err_led;
   logic [1:0] fault_code;

   int n_cmp = 0;
   int n_bad = 0;

   // input vector {load, det, start, cancel, water_ok, finish, error}
   localparam logic [6:0] NO = 7'b0000000;
   localparam logic [6:0] LD = 7'b1000000;
   localparam logic [6:0] DT = 7'b0100000;
   localparam logic [6:0] ST = 7'b0010000;
   localparam logic [6:0] CN = 7'b0001000;
   localparam logic [6:0] WK = 7'b0000100;
   localparam logic [6:0] FN = 7'b0000010;
   localparam logic [6:0] ER = 7'b0000001;

   // output vector {clothes, det, tap, lock, busy, buzzer, done, err, code[1:0]}
   localparam logic [9:0] E0    = 10'b0000000000;
   localparam logic [9:0] EREQ  = 10'b1111100000;
   localparam logic [9:0] ERUN  = 10'b0001100000;
   localparam logic [9:0] EDONE = 10'b0000011000;
   localparam logic [9:0] ENW   = 10'b0000000101;
   localparam logic [9:0] ETO   = 10'b0000000110;

   typedef struct {
      int unsigned n;
      logic [6:0]  in;
      logic [9:0]  exp;
   } vec_t;

   vec_t tbl[$];

   wash_panel_seq dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_btn_load   (btn_load),
      .i_btn_det    (btn_det),
      .i_btn_start  (btn_start),
      .i_btn_cancel (btn_cancel),
      .i_water_ok   (water_ok),
      .i_finish     (finish),
      .i_error      (error),
      .o_clothes    (clothes),
      .o_det_liquid (det_liquid),
      .o_water_tap  (water_tap),
      .o_door_lock  (door_lock),
      .o_busy       (busy),
      .o_buzzer     (buzzer),
      .o_done_led   (done_led),
      .o_err_led    (err_led),
      .o_fault_code (fault_code)
   );

   always #5 clk = ~clk;

   function automatic logic [9:0] outs();
      return {clothes, det_liquid, water_tap, door_lock, busy, buzzer, done_led, err_led, fault_code};
   endfunction

   task automatic apply(input logic [6:0] v);
      {btn_load, btn_det, btn_start, btn_cancel, water_ok, finish, error} = v;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [6:0] v, input int n);
      apply(v);
      repeat (n) step();
   endtask

   task automatic chk(input string nm, input logic [9:0] exp);
      logic [9:0] got;
      got = outs();
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b want %b", nm, got, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      apply(NO);
      step();
      rst = 1'b0;
   endtask

   // Arms the panel and steps through REQUEST; returns with RUN just entered (timer 0).
   task automatic go_run();
      do_reset();
      drive(LD, 4);
      drive(NO, 1);
      drive(DT, 4);
      drive(NO, 1);
      drive(ST | WK, 4);
      drive(WK, 3);
      apply(NO);
      chk("run_entry", ERUN);
   endtask

   function automatic void add(input int unsigned n, input logic [6:0] in, input logic [9:0] exp);
      vec_t v;
      v.n = n;
      v.in = in;
      v.exp = exp;
      tbl.push_back(v);
   endfunction

   initial begin
      // happy path: load, det, start, 3 request cycles, short run, finish, buzzer
      add(4, LD, E0);          add(1, NO, E0);
      add(4, DT, E0);          add(1, NO, E0);
      add(3, ST | WK, E0);     add(1, ST | WK, EREQ);
      add(2, WK, EREQ);        add(1, WK, ERUN);
      add(5, NO, ERUN);        add(1, FN, EDONE);
      add(7, NO, EDONE);       add(1, NO, E0);
      // no water at start -> fault 01, cancel clears it
      add(4, LD, E0);          add(4, DT, E0);
      add(3, ST, E0);          add(1, ST, ENW);
      add(2, NO, ENW);         add(3, CN, ENW);
      add(1, CN, E0);
      // 3-cycle glitch on load is not a press, so start does nothing
      add(3, LD, E0);          add(1, NO, E0);
      add(4, DT, E0);          add(1, NO, E0);
      add(4, ST | WK, E0);     add(2, NO, E0);
      // long hold = one press: arm, cancel, re-latch det only, start ignored
      add(50, LD, E0);         add(4, LD | CN, E0);
      add(4, LD | DT, E0);     add(4, LD | ST | WK, E0);
      add(1, NO, E0);
      // cancel and start together in ARMED: cancel wins
      add(4, LD, E0);          add(4, CN | ST | WK, E0);
      add(1, NO, E0);          add(4, ST | WK, E0);
      add(1, NO, E0);
      // error in 2nd REQUEST cycle -> fault 01
      add(4, LD, E0);          add(4, DT, E0);
      add(3, ST | WK, E0);     add(1, ST | WK, EREQ);
      add(1, WK, EREQ);        add(1, WK | ER, ENW);
      add(3, CN, ENW);         add(1, CN, E0);
      // cancel press inside REQUEST -> IDLE
      add(4, LD, E0);          add(4, DT, E0);
      add(1, ST | WK, E0);     add(2, ST | CN | WK, E0);
      add(1, ST | CN | WK, EREQ);
      add(1, CN | WK, E0);     add(1, NO, E0);

      do_reset();
      chk("reset", E0);

      for (int i = 0; i < tbl.size(); i++) begin
         for (int k = 0; k < int'(tbl[i].n); k++) begin
            apply(tbl[i].in);
            step();
            chk($sformatf("vec%0d.%0d", i, k), tbl[i].exp);
         end
      end

      // finish at RUN cycle 100, with an ignored error at cycle 50
      go_run();
      drive(NO, 50);
      apply(ER);
      step();
      chk("run_error_ignored", ERUN);
      drive(NO, 49);
      apply(FN);
      step();
      chk("finish100_done", EDONE);
      apply(NO);
      for (int k = 0; k < 7; k++) begin
         step();
         chk($sformatf("buzz%0d", k + 1), EDONE);
      end
      step();
      chk("done_to_idle", E0);

      // timeout: no finish for 200 RUN cycles
      go_run();
      drive(NO, 199);
      chk("pre_timeout", ERUN);
      step();
      chk("timeout", ETO);
      drive(CN, 4);
      chk("timeout_cancel", E0);

      // finish on the timeout cycle wins
      go_run();
      drive(NO, 199);
      apply(FN);
      step();
      chk("finish199", EDONE);

      // reset mid-RUN clears everything including latches
      go_run();
      drive(NO, 10);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("reset_mid_run", E0);
      drive(ST | WK, 4);
      chk("after_reset_start", E0);
      drive(NO, 1);
      chk("after_reset_idle", E0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
